// File: rtl/pwm_window_gen.sv
// Multi-channel window generator: one shared modulo-P counter, per-channel active-low windows,
// shadow config applied at the wrap edge. Optional one-shot mode: PWM_WINDOW_GEN_ONESHOT_EN.
module pwm_window_gen #(
    parameter int WIDTH        = 9,
    parameter int CHANNELS     = 2,
    parameter int DEF_PERIOD   = 500,
    parameter int DEF_LO_START = 20,
    parameter int DEF_LO_END   = 90
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
`ifdef PWM_WINDOW_GEN_ONESHOT_EN
    input  logic                      oneshot,
`endif
    input  logic                      cfg_load,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic [CHANNELS*WIDTH-1:0] cfg_lo_start,
    input  logic [CHANNELS*WIDTH-1:0] cfg_lo_end,
    output logic [WIDTH-1:0]          count,
    output logic [CHANNELS-1:0]       f,
    output logic                      wrap,
    output logic                      cfg_pending
);
    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        return (p < WIDTH'(2)) ? WIDTH'(2) : p;
    endfunction

    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    period_q, period_d, sh_period_q, sh_period_d;
    logic [WIDTH-1:0]    start_q [CHANNELS];
    logic [WIDTH-1:0]    start_d [CHANNELS];
    logic [WIDTH-1:0]    end_q [CHANNELS];
    logic [WIDTH-1:0]    end_d [CHANNELS];
    logic [WIDTH-1:0]    sh_start_q [CHANNELS];
    logic [WIDTH-1:0]    sh_start_d [CHANNELS];
    logic [WIDTH-1:0]    sh_end_q [CHANNELS];
    logic [WIDTH-1:0]    sh_end_d [CHANNELS];
    logic [CHANNELS-1:0] f_q, f_d;
    logic                wrap_q, wrap_d, pend_q, pend_d;
    logic                at_end, restart_now, hold_done;

    assign at_end = (count_q == period_q - 1'b1);

`ifdef PWM_WINDOW_GEN_ONESHOT_EN
    logic done_q, done_d, en_prev_q;
    // A finished one-shot restarts on an enable rising edge or a config load.
    assign restart_now = done_q && (cfg_load || (enable && !en_prev_q));
    assign hold_done   = done_q && !restart_now;

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q    <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            en_prev_q <= enable;
        end
    end
`else
    assign restart_now = 1'b0;
    assign hold_done   = 1'b0;
`endif

    always_comb begin
        count_d     = count_q;
        f_d         = f_q;
        wrap_d      = 1'b0;
        pend_d      = pend_q;
        period_d    = period_q;
        sh_period_d = sh_period_q;
        start_d     = start_q;
        end_d       = end_q;
        sh_start_d  = sh_start_q;
        sh_end_d    = sh_end_q;
`ifdef PWM_WINDOW_GEN_ONESHOT_EN
        done_d      = done_q;
`endif
        if (cfg_load) begin
            sh_period_d = cfg_period;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_start_d[i] = cfg_lo_start[i*WIDTH +: WIDTH];
                sh_end_d[i]   = cfg_lo_end[i*WIDTH +: WIDTH];
            end
            pend_d = 1'b1;
        end
        if (enable) begin
            for (int i = 0; i < CHANNELS; i++)
                f_d[i] = !((start_q[i] <= count_q) && (count_q < end_q[i]));
            if (restart_now) begin
                count_d = '0;
`ifdef PWM_WINDOW_GEN_ONESHOT_EN
                done_d  = 1'b0;
`endif
            end else if (!hold_done) begin
                if (at_end) begin
                    wrap_d  = 1'b1;
                    count_d = '0;
`ifdef PWM_WINDOW_GEN_ONESHOT_EN
                    if (oneshot) begin
                        count_d = count_q;
                        done_d  = 1'b1;
                    end
`endif
                    // A load coinciding with the wrap edge bypasses the shadow.
                    if (cfg_load) begin
                        period_d = clamp_period(cfg_period);
                        for (int i = 0; i < CHANNELS; i++) begin
                            start_d[i] = cfg_lo_start[i*WIDTH +: WIDTH];
                            end_d[i]   = cfg_lo_end[i*WIDTH +: WIDTH];
                        end
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        period_d = clamp_period(sh_period_q);
                        start_d  = sh_start_q;
                        end_d    = sh_end_q;
                        pend_d   = 1'b0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end else if (pend_q) begin
            // Applying while idle restarts the count so it stays below a shrunk period.
            period_d = clamp_period(sh_period_q);
            start_d  = sh_start_q;
            end_d    = sh_end_q;
            count_d  = '0;
            pend_d   = cfg_load;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            f_q         <= '1;
            wrap_q      <= 1'b0;
            pend_q      <= 1'b0;
            period_q    <= WIDTH'(DEF_PERIOD);
            sh_period_q <= WIDTH'(DEF_PERIOD);
            for (int i = 0; i < CHANNELS; i++) begin
                start_q[i]    <= WIDTH'(DEF_LO_START);
                end_q[i]      <= WIDTH'(DEF_LO_END);
                sh_start_q[i] <= WIDTH'(DEF_LO_START);
                sh_end_q[i]   <= WIDTH'(DEF_LO_END);
            end
        end else begin
            count_q     <= count_d;
            f_q         <= f_d;
            wrap_q      <= wrap_d;
            pend_q      <= pend_d;
            period_q    <= period_d;
            sh_period_q <= sh_period_d;
            start_q     <= start_d;
            end_q       <= end_d;
            sh_start_q  <= sh_start_d;
            sh_end_q    <= sh_end_d;
        end
    end

    assign count       = count_q;
    assign f           = f_q;
    assign wrap        = wrap_q;
    assign cfg_pending = pend_q;
endmodule
